maxunpool: RTL and testbench

Streaming 2x2 max-unpooling block: the inverse of the pooling stage. It accepts pooled values, each with the 2-bit argmax position recorded at pooling time. It emits the full-resolution map in raster order, with each value placed at its argmax position and zeros in the other three positions of its window. It sits on the decoder/upsampling path of the CNN datapath, downstream of whatever stores pooled values and indices.

---
 rtl/maxunpool_pkg.sv | 36 +++
 rtl/maxunpool_row_buffer.sv | 33 +++
 rtl/maxunpool.sv | 210 +++++++++++++++++++++
 tb/tb_maxunpool.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maxunpool_pkg.sv
// Shared definitions for the max-unpooling block: FSM state encoding and
// the 2-bit argmax position codes used by index-producing pooling stages.
//   unpool_state_t : UP_IDLE, UP_LOAD, UP_EMIT_TOP, UP_EMIT_BOT, UP_DONE
//   POOL_IDX_*     : argmax position inside a 2x2 window
//   pool_idx_hit   : does a stored argmax code land on (row half, column lsb)
package maxunpool_pkg;

   typedef enum logic [2:0] {
      UP_IDLE     = 3'd0,
      UP_LOAD     = 3'd1,
      UP_EMIT_TOP = 3'd2,
      UP_EMIT_BOT = 3'd3,
      UP_DONE     = 3'd4
   } unpool_state_t;

   localparam logic [1:0] POOL_IDX_TL = 2'd0;
   localparam logic [1:0] POOL_IDX_TR = 2'd1;
   localparam logic [1:0] POOL_IDX_BL = 2'd2;
   localparam logic [1:0] POOL_IDX_BR = 2'd3;

   // True when argmax code 'idx' addresses the window position at
   // (half: 0 top / 1 bottom, col_lsb: 0 left / 1 right).
   function automatic logic pool_idx_hit(input logic [1:0] idx,
                                         input logic       half,
                                         input logic       col_lsb);
      logic hit;
      case ({half, col_lsb})
         2'b00:   hit = (idx == POOL_IDX_TL);
         2'b01:   hit = (idx == POOL_IDX_TR);
         2'b10:   hit = (idx == POOL_IDX_BL);
         default: hit = (idx == POOL_IDX_BR);
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/maxunpool_row_buffer.sv
// One pooled row of {argmax idx, value} entries.
// Ports:
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write column
//   i_wdata  : {idx, value} entry to store
//   i_raddr  : read column (combinational read)
//   o_rdata  : entry at i_raddr
// Storage has no reset: every entry is rewritten before it is read.
module maxunpool_row_buffer #(
   parameter int unsigned ENTRY_W = 10,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ADDR_W  = 2
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [ADDR_W-1:0]  i_waddr,
   input  logic [ENTRY_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0]  i_raddr,
   output logic [ENTRY_W-1:0] o_rdata
);

   logic [ENTRY_W-1:0] r_mem [DEPTH];

   // Write port
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Combinational read port
   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/maxunpool.sv
// Streaming 2x2 max-unpooling: loads one pooled row of {value, argmax idx}
// tokens, then emits the two full-resolution rows it expands to, placing each
// value at its argmax position and zeros elsewhere.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_en                    : frame start (honoured in UP_IDLE / UP_DONE)
//   i_in_valid, o_in_ready  : pooled token handshake
//   i_in_data, i_in_idx     : pooled value and its argmax position
//   o_out_valid, i_out_ready: output pixel handshake
//   o_out_data, o_out_last  : output pixel, last pixel of frame
//   o_done_unpool           : frame complete, held until next en or reset
module maxunpool
   import maxunpool_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IN_HEIGHT  = 4,
   parameter int unsigned IN_WIDTH   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [DATA_WIDTH-1:0] i_in_data,
   input  logic [1:0]            i_in_idx,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic                  o_out_last,
   output logic                  o_done_unpool
);

   localparam int unsigned ENTRY_W = DATA_WIDTH + 2;
   localparam int unsigned ADDR_W  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam int unsigned COL_W   = $clog2(2 * IN_WIDTH);
   localparam int unsigned ROW_W   = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

   localparam logic [COL_W-1:0] LOAD_LAST = COL_W'(IN_WIDTH - 1);
   localparam logic [COL_W-1:0] EMIT_LAST = COL_W'(2 * IN_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IN_HEIGHT - 1);

   unpool_state_t         r_state;
   logic [COL_W-1:0]      r_col;
   logic [ROW_W-1:0]      r_row;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_last;
   logic                  r_done;

   logic                  w_we;
   logic [ADDR_W-1:0]     w_waddr;
   logic [ENTRY_W-1:0]    w_wdata;
   logic [ADDR_W-1:0]     w_raddr;
   logic [ENTRY_W-1:0]    w_rdata;
   logic [ENTRY_W-1:0]    w_entry;
   logic                  w_la_half;
   logic [COL_W-1:0]      w_la_col;
   logic [DATA_WIDTH-1:0] w_la_pix;
   logic                  w_la_last;

   assign w_we    = (r_state == UP_LOAD) && i_in_valid;
   assign w_waddr = ADDR_W'(r_col);
   assign w_wdata = {i_in_idx, i_in_data};

   maxunpool_row_buffer #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (IN_WIDTH),
      .ADDR_W  (ADDR_W)
   ) u_row_buffer (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // Position of the pixel that becomes current after the next advance.
   // Outputs are registered, so each pixel is prepared one step ahead.
   always_comb begin
      w_la_half = 1'b0;
      w_la_col  = '0;
      case (r_state)
         UP_EMIT_TOP: begin
            if (r_col == EMIT_LAST) begin
               w_la_half = 1'b1;
               w_la_col  = '0;
            end else begin
               w_la_col = r_col + COL_W'(1);
            end
         end
         UP_EMIT_BOT: begin
            w_la_half = 1'b1;
            if (r_col != EMIT_LAST) w_la_col = r_col + COL_W'(1);
         end
         default: ;
      endcase
   end

   assign w_raddr = ADDR_W'(w_la_col >> 1);

   // Bypass covers a single-column row, where pixel 0 comes from the
   // token being written in the same cycle.
   assign w_entry = (w_we && (w_waddr == w_raddr)) ? w_wdata : w_rdata;

   assign w_la_pix  = pool_idx_hit(w_entry[ENTRY_W-1 -: 2], w_la_half, w_la_col[0])
                      ? w_entry[DATA_WIDTH-1:0] : '0;
   assign w_la_last = w_la_half && (w_la_col == EMIT_LAST) && (r_row == ROW_LAST);

   // Control FSM with counters and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= UP_IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            UP_IDLE: begin
               if (i_en) begin
                  r_state    <= UP_LOAD;
                  r_col      <= '0;
                  r_row      <= '0;
                  r_in_ready <= 1'b1;
               end
            end
            UP_LOAD: begin
               if (i_in_valid) begin
                  if (r_col == LOAD_LAST) begin
                     r_state     <= UP_EMIT_TOP;
                     r_col       <= '0;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_la_pix;
                     r_out_last  <= 1'b0;
                  end else begin
                     r_col <= r_col + COL_W'(1);
                  end
               end
            end
            UP_EMIT_TOP: begin
               if (i_out_ready) begin
                  if (r_col == EMIT_LAST) begin
                     r_state <= UP_EMIT_BOT;
                     r_col   <= '0;
                  end else begin
                     r_col <= r_col + COL_W'(1);
                  end
                  r_out_data <= w_la_pix;
                  r_out_last <= w_la_last;
               end
            end
            UP_EMIT_BOT: begin
               if (i_out_ready) begin
                  if (r_col == EMIT_LAST) begin
                     r_col       <= '0;
                     r_out_valid <= 1'b0;
                     r_out_data  <= '0;
                     r_out_last  <= 1'b0;
                     if (r_row == ROW_LAST) begin
                        r_state <= UP_DONE;
                        r_row   <= '0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state    <= UP_LOAD;
                        r_row      <= r_row + ROW_W'(1);
                        r_in_ready <= 1'b1;
                     end
                  end else begin
                     r_col      <= r_col + COL_W'(1);
                     r_out_data <= w_la_pix;
                     r_out_last <= w_la_last;
                  end
               end
            end
            UP_DONE: begin
               if (i_en) begin
                  r_state    <= UP_LOAD;
                  r_col      <= '0;
                  r_row      <= '0;
                  r_in_ready <= 1'b1;
                  r_done     <= 1'b0;
               end
            end
            default: begin
               r_state     <= UP_IDLE;
               r_col       <= '0;
               r_row       <= '0;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_out_data  <= '0;
               r_out_last  <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready    = r_in_ready;
   assign o_out_valid   = r_out_valid;
   assign o_out_data    = r_out_data;
   assign o_out_last    = r_out_last;
   assign o_done_unpool = r_done;

endmodule

// File: tb/tb_maxunpool.sv
// Bench for maxunpool (2x2 pooled map -> 4x4 output): directed frames from the
// example table plus randomized tokens and handshakes, checked against a
// window-placement reference model.
module tb_maxunpool;

   localparam int DW   = 8;
   localparam int H    = 2;
   localparam int W    = 2;
   localparam int NTOK = H * W;
   localparam int NPIX = 4 * H * W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [1:0]    in_idx;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          done_unpool;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] tok_d  [NTOK];
   logic [1:0]    tok_i  [NTOK];
   logic [DW-1:0] exp_d  [NPIX];
   logic          exp_l  [NPIX];
   logic [DW-1:0] got_d  [NPIX];
   logic [DW-1:0] s1_ref [NPIX];

   always #5 clk = ~clk;

   maxunpool #(.DATA_WIDTH(DW), .IN_HEIGHT(H), .IN_WIDTH(W)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_en          (en),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_in_data     (in_data),
      .i_in_idx      (in_idx),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready),
      .o_out_data    (out_data),
      .o_out_last    (out_last),
      .o_done_unpool (done_unpool)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: each token expands to a 2x2 window, value at its argmax slot.
   task automatic build_expected();
      for (int r = 0; r < H; r++)
         for (int h = 0; h < 2; h++)
            for (int c = 0; c < 2 * W; c++) begin
               int p;
               int k;
               p = (2 * r + h) * 2 * W + c;
               k = r * W + c / 2;
               exp_d[p] = (int'(tok_i[k]) == 2 * h + c % 2) ? tok_d[k] : '0;
               exp_l[p] = (p == NPIX - 1);
            end
   endtask

   task automatic rand_tokens();
      for (int i = 0; i < NTOK; i++) begin
         tok_d[i] = DW'($urandom);
         tok_i[i] = 2'($urandom);
      end
   endtask

   task automatic set_s1_tokens();
      tok_d[0] = 8'd5; tok_i[0] = 2'd0;
      tok_d[1] = 8'd7; tok_i[1] = 2'd3;
      tok_d[2] = 8'd9; tok_i[2] = 2'd1;
      tok_d[3] = 8'd2; tok_i[3] = 2'd2;
   endtask

   task automatic cmp_s1(input string tag);
      for (int i = 0; i < NPIX; i++)
         chk($sformatf("%s_pix%0d", tag, i), 32'(got_d[i]), 32'(s1_ref[i]));
   endtask

   // vmode: 0 in_valid always high, 1 pattern 1,0,0,1, 2 random.
   // Called at a negedge; returns at the negedge after the final output transfer.
   task automatic run_frame(input int vmode, input int rprob, input int stall_pix,
                            input bit check_time, input bit from_done);
      int ti = 0;
      int pi = 0;
      int cyc = 0;
      int stall_cnt = 0;
      build_expected();
      en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      if (from_done) chk("done_drop_after_en", 32'(done_unpool), 32'd0);
      while (pi < NPIX && cyc < 2000) begin
         int  row_now;
         bit  exp_ir;
         case (vmode)
            0:       in_valid = 1'b1;
            1:       in_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: in_valid = 1'($urandom);
         endcase
         if (ti < NTOK) begin
            in_data = tok_d[ti];
            in_idx  = tok_i[ti];
         end else begin
            in_data = DW'($urandom);
            in_idx  = 2'($urandom);
         end
         if (stall_pix == pi && stall_cnt < 3 && out_valid) begin
            out_ready = 1'b0;
            stall_cnt++;
         end else begin
            out_ready = int'($urandom_range(99)) < rprob;
         end
         // Loading row r while exactly r rows have been emitted and tokens remain for it.
         row_now = pi / (4 * W);
         exp_ir  = (ti < NTOK) && (ti < (row_now + 1) * W);
         chk("in_ready", 32'(in_ready), 32'(exp_ir));
         chk("out_valid", 32'(out_valid), 32'(!exp_ir));
         if (out_valid) begin
            chk($sformatf("pix%0d_data", pi), 32'(out_data), 32'(exp_d[pi]));
            chk($sformatf("pix%0d_last", pi), 32'(out_last), 32'(exp_l[pi]));
         end else begin
            chk("data_zero_when_invalid", 32'(out_data), 32'd0);
         end
         if (in_valid && in_ready) ti++;
         if (out_valid && out_ready) begin
            got_d[pi] = out_data;
            pi++;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      chk("frame_pixels", 32'(pi), 32'(NPIX));
      if (check_time) chk("frame_cycles", 32'(cyc), 32'(H * (W + 4 * W)));
      chk("done_high", 32'(done_unpool), 32'd1);
      chk("done_out_valid", 32'(out_valid), 32'd0);
      chk("done_in_ready", 32'(in_ready), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      s1_ref = '{8'd5, 8'd0, 8'd0, 8'd0,
                 8'd0, 8'd0, 8'd0, 8'd7,
                 8'd0, 8'd9, 8'd0, 8'd0,
                 8'd0, 8'd0, 8'd2, 8'd0};
      rst_n     = 1'b0;
      en        = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_idx    = '0;
      out_ready = 1'b0;

      // Reset values
      #22;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_done", 32'(done_unpool), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // in_valid while idle is ignored
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("idle_in_ready", 32'(in_ready), 32'd0);
         chk("idle_out_valid", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b0;

      // Example frame, full throughput, exact frame time
      set_s1_tokens();
      run_frame(0, 100, -1, 1'b1, 1'b0);
      cmp_s1("s1");

      // Same frame with a 3-cycle output stall, started from UP_DONE
      run_frame(0, 100, 5, 1'b0, 1'b1);
      cmp_s1("s2");

      // in_valid toggling 1,0,0,1 and high while emitting
      run_frame(1, 100, -1, 1'b0, 1'b1);
      cmp_s1("s3");

      // 0xFF with argmax bottom-right in the last column of the first row
      rand_tokens();
      tok_d[W - 1] = 8'hFF;
      tok_i[W - 1] = 2'd3;
      run_frame(2, 70, -1, 1'b0, 1'b1);
      chk("ff_br_pixel", 32'(got_d[2 * W + 2 * W - 1]), 32'hFF);
      chk("ff_tl_pixel", 32'(got_d[2 * W - 2]), 32'd0);
      chk("ff_tr_pixel", 32'(got_d[2 * W - 1]), 32'd0);
      chk("ff_bl_pixel", 32'(got_d[2 * W + 2 * W - 2]), 32'd0);

      // Reset asserted while emitting the bottom row
      rand_tokens();
      en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en        = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < W + 2 * W + 1; i++) begin
         in_data = DW'($urandom);
         in_idx  = 2'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      chk("pre_abort_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_last", 32'(out_last), 32'd0);
      chk("abort_done", 32'(done_unpool), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_abort_idle", 32'(in_ready), 32'd0);
      rand_tokens();
      run_frame(2, 60, -1, 1'b0, 1'b0);

      // Back-to-back random frames restarted from UP_DONE
      for (int f = 0; f < 6; f++) begin
         rand_tokens();
         run_frame(2, 30 + 10 * f, -1, 1'b0, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
